// File: rtl/sorter_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : sorter_frame_collector
// Brief    : Packs a serial valid/ready word stream into N-word padded frames
//            for the combinational sorter network.
// Revision : 1.0 - initial release
// ============================================================================
module sorter_frame_collector #(
    parameter  int            N   = 5,
    parameter  int            DW  = 8,
    parameter  logic [DW-1:0] PAD = {DW{1'b1}},
    localparam int            CW  = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [DW*N-1:0] frame_data,
    output logic            frame_valid,
    input  logic            frame_ready,
    output logic [CW-1:0]   frame_count
);

    localparam int                c_cntw      = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cntw-1:0] c_last_slot = c_cntw'(N - 1);

    localparam logic [0:0] c_fill = 1'b0;
    localparam logic [0:0] c_hold = 1'b1;

    logic [0:0]        r_state;
    logic [c_cntw-1:0] r_cnt;
    logic [CW-1:0]     r_count;
    logic [DW-1:0]     r_slot [N];

    logic w_accept;
    logic w_deliver;
    logic w_close;

    // Handshake outputs depend only on state and frame_ready, never on in_valid.
    assign frame_valid = (r_state == c_hold);
    assign in_ready    = (r_state == c_fill) | frame_ready;
    assign frame_count = r_count;

    assign w_accept  = in_valid & in_ready;
    assign w_deliver = frame_valid & frame_ready;
    assign w_close   = in_last | (r_cnt == c_last_slot);

    generate
        for (genvar k = 0; k < N; k++) begin : g_slot
            assign frame_data[DW*(N-k)-1 -: DW] = r_slot[k];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_fill;
            r_cnt   <= '0;
            r_count <= '0;
            for (int k = 0; k < N; k++) begin
                r_slot[k] <= PAD;
            end
        end else begin
            case (r_state)
                c_fill: begin
                    if (w_accept) begin
                        r_slot[r_cnt] <= in_data;
                        if (w_close) begin
                            r_state <= c_hold;
                            r_count <= CW'(r_cnt) + CW'(1);
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cntw'(1);
                        end
                    end
                end
                c_hold: begin
                    if (w_deliver) begin
                        for (int k = 0; k < N; k++) begin
                            r_slot[k] <= PAD;
                        end
                        // A word taken in the handoff cycle opens the next frame in slot 0.
                        if (w_accept) begin
                            r_slot[0] <= in_data;
                            if (in_last) begin
                                r_count <= CW'(1);
                            end else begin
                                r_state <= c_fill;
                                r_cnt   <= c_cntw'(1);
                            end
                        end else begin
                            r_state <= c_fill;
                        end
                    end
                end
                default: r_state <= c_fill;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sorter_frame_collector.md
# sorter_frame_collector

Upstream feeder for the combinational `sorter` network. Accepts a serial stream of DW-bit words over a valid/ready handshake, packs N of them into the flat DW*N vector the sorter consumes, and presents the frame with its own valid/ready handshake. Frames shorter than N, terminated by `in_last`, are padded with PAD.

## Interface
- `N`, 5, words per frame; N >= 2.
- `DW`, 8, word width in bits.
- `PAD`, 2**DW-1 (all ones), fill value for unwritten slots of a short frame.
- `CW`, $clog2(N+1), width of `frame_count` (derived, not overridden).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_data`  in  DW  stream word.
- `in_valid`  in  1  `in_data` and `in_last` are valid.
- `in_last`  in  1  this word closes the current frame.
- `in_ready`  out  1  block accepts a word this cycle.
- `frame_data`  out  DW*N  packed frame; slot k at bits [DW*(N-k)-1 : DW*(N-k-1)], slot 0 in the MSBs (first word received).
- `frame_valid`  out  1  `frame_data` / `frame_count` hold a complete frame.
- `frame_ready`  in  1  downstream takes the frame.
- `frame_count`  out  CW  number of real (non-pad) words in the frame, 1..N.

## Operation
- Word accepted when `in_valid && in_ready`. Frame delivered when `frame_valid && frame_ready`.
- Internal state: `FILL` / `HOLD`, slot counter `cnt` (0..N-1), N slot registers.
- FILL: `in_ready`=1, `frame_valid`=0. On accept: write `in_data` to slot `cnt`.
  - If `in_last` or `cnt`==N-1: go HOLD, `frame_count`<=`cnt`+1, `cnt`<=0.
  - Else `cnt`<=`cnt`+1.
- HOLD: `frame_valid`=1, `in_ready`=`frame_ready`. Slots, `frame_count` frozen while `frame_ready`=0.
  - On delivery with no word accepted: all slots <= PAD, go FILL.
  - On delivery with word accepted in the same cycle: slot 0 <= `in_data`, slots 1..N-1 <= PAD. If that word has `in_last`, stay HOLD with `frame_count`<=1. Otherwise go FILL with `cnt`<=1.
- Padding: slots not written since the last clear hold PAD. A frame closed after k words has slots k..N-1 = PAD.
- `in_last` on the Nth word is identical to a full frame. `in_last` with `in_valid`=0 is ignored.
- In FILL, `frame_data` shows the partial frame and must not be sampled. In FILL, `frame_count` keeps its last value.
- Reset (any time, including mid-frame or in HOLD) discards the partial or held frame with no delivery.

## Timing
- Reset values: `frame_valid`=0, `in_ready`=1 (FILL), `frame_data`=all PAD, `frame_count`=0, `cnt`=0.
- `in_ready` and `frame_valid` are decoded from registered state plus `frame_ready`. There is no combinational path from `in_valid` to `in_ready`.
- Latency: the word closing a frame is accepted at edge t, and `frame_valid` is 1 from edge t onward.
- Throughput: with `frame_ready` held 1 and `in_valid` held 1, one word is accepted every cycle with no bubbles. Full frames are delivered every N cycles.
- Backpressure: `frame_data` and `frame_count` are stable from `frame_valid` rising until delivery. `in_ready`=0 throughout.
- Output is registered, and the downstream sorter adds only combinational delay.

## Test plan
- Full frame, N=5, DW=8: send 0x10,0x20,0x30,0x40,0x50 on consecutive cycles with `frame_ready`=1. Required response: `frame_valid` rises after the 5th accept, `frame_data`=0x1020304050, `frame_count`=5.
- Short frame: send 0x07,0x03 with `in_last` on 0x03. Required response: `frame_data`=0x0703FFFFFF, `frame_count`=2.
- Backpressure: after a full frame completes, hold `frame_ready`=0 for 6 cycles with `in_valid`=1 and new data presented. Required response: `in_ready`=0 and `frame_data` unchanged for all 6 cycles, and no words accepted. Raise `frame_ready` and the new word lands in slot 0 in the same cycle.
- Back-to-back stream: 3 full frames, continuous `in_valid`, `frame_ready`=1. Required response: 15 accepts in 15 cycles, `frame_valid` pulses once every 5 cycles, and each frame's data matches its input order.
- Single-word frame in handoff cycle: in HOLD, deliver while accepting 0xAA with `in_last`. Required response: the next frame is 0xAAFFFFFFFF with `frame_count`=1, and `frame_valid` stays 1.
- Reset mid-operation: drop `rst_n` asynchronously after 3 words. Required response: outputs immediately go to reset values (`frame_valid`=0, `frame_data` all 0xFF). After release, a fresh 5-word frame is delivered with none of the old words present.
